mux_4_1_arb: RTL

Four-channel to one-channel arbitrating multiplexer: the gathering counterpart of the 1:4 demultiplexer. It accepts words from four valid/ready source channels, selects one per cycle, and presents it on a single registered output together with a 2-bit `sel` tag naming the source channel. A downstream `demux_1_4` can use that tag directly to route the word back out. It sits between four producers and one shared link, with one output holding register.

---
 rtl/mux_4_1_arb_if.sv | 20 ++
 rtl/mux_4_1_arb.sv | 85 ++++++++
 2 files changed

// File: rtl/mux_4_1_arb_if.sv
// Handshake bundle for the 4:1 arbitrating multiplexer: four source channels in, one tagged channel out.
interface mux_4_1_arb_if #(parameter int W = 8);
    logic [W-1:0] i0, i1, i2, i3;
    logic         v0, v1, v2, v3;
    logic         r0, r1, r2, r3;
    logic [W-1:0] y;
    logic [1:0]   sel;
    logic         y_valid;
    logic         y_ready;

    // master: the arbiter itself; slave: the producers and the downstream consumer
    modport master (
        input  i0, i1, i2, i3, v0, v1, v2, v3, y_ready,
        output r0, r1, r2, r3, y, sel, y_valid
    );
    modport slave (
        output i0, i1, i2, i3, v0, v1, v2, v3, y_ready,
        input  r0, r1, r2, r3, y, sel, y_valid
    );
endinterface

// File: rtl/mux_4_1_arb.sv
// Four valid/ready channels arbitrated into one registered output word tagged with its source.
// Define MUX4_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (channel 0 highest).
module mux_4_1_arb #(
    parameter int W = 8
) (
    input logic            clk,
    input logic            rst,
    mux_4_1_arb_if.master  bus
);
    logic [3:0]   vv;
    logic [1:0]   base;
    logic [1:0]   idx;
    logic [1:0]   gidx;
    logic         gnt_any;
    logic [3:0]   grant;
    logic         load_en;
    logic [W-1:0] din;
    logic [W-1:0] y_q;
    logic [1:0]   sel_q;
    logic         y_valid_q;

`ifdef MUX4_ROUND_ROBIN_EN
    logic [1:0] ptr;
    assign base = ptr;
`else
    assign base = '0;
`endif

    assign vv      = {bus.v3, bus.v2, bus.v1, bus.v0};
    assign load_en = !y_valid_q || bus.y_ready;

    // Search starts at base and wraps; first requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gidx    = '0;
        idx     = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = base + k[1:0];
            if (!gnt_any && vv[idx]) begin
                gnt_any = 1'b1;
                gidx    = idx;
            end
        end
    end

    assign grant = gnt_any ? (4'b0001 << gidx) : 4'b0000;

    always_comb begin
        case (gidx)
            2'd0:    din = bus.i0;
            2'd1:    din = bus.i1;
            2'd2:    din = bus.i2;
            default: din = bus.i3;
        endcase
    end

    // Readies are masked during reset so nothing is handed off on a reset edge.
    assign {bus.r3, bus.r2, bus.r1, bus.r0} = grant & {4{load_en && !rst}};

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            sel_q     <= '0;
            y_valid_q <= 1'b0;
`ifdef MUX4_ROUND_ROBIN_EN
            ptr       <= '0;
`endif
        end else if (load_en) begin
            if (gnt_any) begin
                y_q       <= din;
                sel_q     <= gidx;
                y_valid_q <= 1'b1;
`ifdef MUX4_ROUND_ROBIN_EN
                ptr       <= gidx + 2'd1;
`endif
            end else begin
                y_valid_q <= 1'b0;
            end
        end
    end

    assign bus.y       = y_q;
    assign bus.sel     = sel_q;
    assign bus.y_valid = y_valid_q;
endmodule
